// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl_if : decoder, pipeline-register and data-memory signals
//                       exchanged with the hazard controller.  Rev 1.0
// ============================================================================
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_jump;
  logic              id_jr;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_branch_taken;
  logic              mem_req;
  logic              mem_ready;
  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic              idex_en;
  logic              idex_flush;
  logic              exmem_en;
  logic              memwb_en;
  logic [1:0]        state;
  logic [CNT_W-1:0]  stall_cnt;
  logic              mem_timeout;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_jump, id_jr,
           ex_mem_read, ex_rd, ex_branch_taken, mem_req, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_en, state, stall_cnt, mem_timeout
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_jump, id_jr,
           ex_mem_read, ex_rd, ex_branch_taken, mem_req, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_en, state, stall_cnt, mem_timeout
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl : 5-stage pipeline sequencing (load-use stall, control-flow
//                    flush, data-memory wait with timeout).  Rev 1.0
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int REG_AW  = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input wire                clk,
  input wire                rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] C_TIMEOUT = WAIT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  C_CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              timeout_q, timeout_d;

  logic              w_lu;
  logic              w_mem_done;
  logic [WAIT_W-1:0] w_wait_inc;
  logic              w_freeze;
  logic              w_pc_en;
  logic              w_ifid_en;
  logic              w_ifid_flush;
  logic              w_idex_en;
  logic              w_idex_flush;
  logic              w_exmem_en;
  logic              w_memwb_en;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign w_lu = bus.ex_mem_read && (bus.ex_rd != '0) &&
                ((bus.id_use_rs && (bus.id_rs == bus.ex_rd)) ||
                 (bus.id_use_rt && (bus.id_rt == bus.ex_rd)));

  assign w_mem_done = bus.mem_req && bus.mem_ready;
  assign w_wait_inc = wait_cnt_q + WAIT_W'(1);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    w_freeze   = 1'b0;
    case (state_q)
      S_RUN: begin
        if (bus.mem_req && !bus.mem_ready) begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
          w_freeze   = 1'b1;
        end
      end
      S_WAIT: begin
        if (w_mem_done) begin
          state_d = S_RUN;
        end else begin
          w_freeze   = 1'b1;
          wait_cnt_d = w_wait_inc;
          if (w_wait_inc >= C_TIMEOUT) begin
            state_d   = S_ERR;
            timeout_d = 1'b1;
          end
        end
      end
      S_ERR: begin
        w_freeze = 1'b1;
      end
      default: begin
        state_d  = S_RUN;
        w_freeze = 1'b1;
      end
    endcase
  end

  // A taken branch squashes everything younger, so it outranks jump and stall.
  always_comb begin
    w_pc_en      = 1'b1;
    w_ifid_en    = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_en    = 1'b1;
    w_idex_flush = 1'b0;
    w_exmem_en   = 1'b1;
    w_memwb_en   = 1'b1;
    if (rst) begin
      w_pc_en = 1'b1;
    end else if (w_freeze) begin
      w_pc_en    = 1'b0;
      w_ifid_en  = 1'b0;
      w_idex_en  = 1'b0;
      w_exmem_en = 1'b0;
      w_memwb_en = 1'b0;
    end else if (bus.ex_branch_taken) begin
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
    end else if (bus.id_jump || bus.id_jr) begin
      w_ifid_flush = 1'b1;
    end else if (w_lu) begin
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_idex_flush = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!w_pc_en && (stall_cnt_q != C_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.pc_en       = w_pc_en;
  assign bus.ifid_en     = w_ifid_en;
  assign bus.ifid_flush  = w_ifid_flush;
  assign bus.idex_en     = w_idex_en;
  assign bus.idex_flush  = w_idex_flush;
  assign bus.exmem_en    = w_exmem_en;
  assign bus.memwb_en    = w_memwb_en;
  assign bus.state       = state_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.mem_timeout = timeout_q;

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage pipeline: generates PC/pipeline-register enables and flushes.
- Handles three hazard classes:
  - load-use stall, from decoded mem_read/write_en in EX;
  - control-flow flush, from branch, jump, jal and jr;
  - multi-cycle data-memory wait, via a req/ready handshake.
- Keeps a saturating stall-cycle counter and a sticky memory-timeout flag.
- Sits between the control decoder outputs, the pipeline registers and the data-memory port.

Parameters:
- REG_AW, 4, register address width.
- CNT_W, 16, stall counter width.
- TIMEOUT, 64, maximum MEM_WAIT cycles before mem_timeout is set.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- id_rs  in  REG_AW  source register A of the instruction in ID.
- id_rt  in  REG_AW  source register B of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_jump  in  1  ID instruction is j or jal (decoder jump).
- id_jr  in  1  ID instruction is jr.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd  in  REG_AW  destination register of the EX instruction.
- ex_branch_taken  in  1  branch in EX resolved taken.
- mem_req  in  1  MEM stage requests data memory (lw/sw).
- mem_ready  in  1  data memory completes the request this cycle.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  clear IF/ID to a bubble.
- idex_en  out  1  ID/EX register load enable.
- idex_flush  out  1  clear ID/EX to a bubble.
- exmem_en  out  1  EX/MEM register load enable.
- memwb_en  out  1  MEM/WB register load enable.
- state  out  2  FSM state (RUN=0, WAIT=1, ERR=2).
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0.
- mem_timeout  out  1  sticky error flag.

Behaviour:
- Reset, synchronous (rst sampled high at a clk edge):
  - state=RUN, stall_cnt=0, mem_timeout=0, wait counter=0.
  - While rst is high, all enables=1 and all flushes=0.
- Outputs are combinational from state and current inputs; no added latency.
- Load-use hazard (lu):
  - lu = ex_mem_read & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)) & ex_rd!=0.
  - Register 0 never hazards.
- FSM state RUN, mem_req=1 and mem_ready=0:
  - Enter WAIT next cycle.
  - This cycle: every enable=0 and every flush=0 (whole pipeline frozen, bubbles not inserted).
- FSM state RUN, otherwise, priority highest first:
  1. ex_branch_taken: ifid_flush=1, idex_flush=1, all enables=1. Overrides lu and id_jump/id_jr, since those instructions are wrong-path.
  2. id_jump or id_jr: ifid_flush=1, all enables=1 (one bubble).
  3. lu: pc_en=0, ifid_en=0, idex_flush=1, downstream enables=1. The stall lasts exactly one cycle because the load advances to MEM.
  4. Otherwise all enables=1 and flushes=0.
- FSM state WAIT:
  - Full freeze (all enables=0, flushes=0); the wait counter increments.
  - mem_ready=1: freeze is released this same cycle and the RUN priority rules above apply to the current inputs; state returns to RUN next cycle.
  - Wait counter reaching TIMEOUT with mem_ready still 0: go to ERR and set mem_timeout=1.
- FSM state ERR:
  - Permanent full freeze; mem_timeout held at 1.
  - Only rst exits.
- Wait counter clears on every entry to WAIT.
- mem_ready while mem_req=0 is ignored.
- stall_cnt increments each cycle pc_en=0 (lu, WAIT, ERR) and saturates at 2^CNT_W-1 with no wrap.
- rst asserted in WAIT or ERR takes precedence over every other input.

Test Plan:
- Load-use: lw to r3 in EX with ID add reading r3 (id_use_rs=1) -> one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables=1; stall_cnt=1.
- r0 and no-use cases:
  - ex_rd=0 with ex_mem_read=1 -> no stall.
  - id_rt match with id_use_rt=0 -> no stall.
- Branch vs stall: ex_branch_taken=1 together with lu=1 and id_jump=1 -> ifid_flush=1, idex_flush=1, pc_en=1, stall_cnt unchanged.
- Memory wait:
  - mem_req=1 with mem_ready low for 3 cycles then high -> all enables=0 for 3 cycles; state=WAIT on cycles 2-3; enables=1 in the ready cycle; RUN afterwards; stall_cnt=3.
- Timeout with TIMEOUT=4:
  - mem_ready held low -> ERR after 4 WAIT cycles, mem_timeout=1, freeze persists.
  - rst high one cycle -> state=RUN, mem_timeout=0, stall_cnt=0.
- Saturation with CNT_W=3: 10 consecutive stall cycles -> stall_cnt stops at 7.
